// File: rtl/clock_pkg.sv
// Types and constants shared by the time-set controller and the 12-hour counter chain.
// Holds the set-mode encoding, the field width and the default terminal counts.
package clock_pkg;

    localparam int TIME_W   = 7;
    localparam int HRS_TC   = 11;
    localparam int MINS_TC  = 59;
    localparam int DBNC_TC  = 999999;
    localparam int BLINK_TC = 24999999;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_SET_HRS  = 2'd1,
        ST_SET_MINS = 2'd2,
        ST_COMMIT   = 2'd3
    } set_state_e;

    // A captured live value outside the field range restarts editing from zero.
    function automatic logic [TIME_W-1:0] clamp_tc(input logic [TIME_W-1:0] v,
                                                   input logic [TIME_W-1:0] tc);
        return (v > tc) ? '0 : v;
    endfunction

    function automatic logic [TIME_W-1:0] step_wrap(input logic [TIME_W-1:0] v,
                                                    input logic [TIME_W-1:0] tc);
        return (v == tc) ? '0 : v + 1'b1;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Debouncer for one raw active-low pushbutton: 2-flop synchronizer, stability counter,
// and a registered one-cycle pulse on each debounced press (high-to-low) edge.
module btn_debounce #(
    parameter int dbnc_tc_p = 999999
) (
    input  logic clk_i,
    input  logic nReset_i,
    input  logic nBtn_i,
    output logic press_o
);

    localparam int CNT_W = (dbnc_tc_p > 0) ? $clog2(dbnc_tc_p + 1) : 1;
    localparam logic [CNT_W-1:0] DBNC_TC_W = CNT_W'(dbnc_tc_p);

    logic             sync0_q, sync0_d;
    logic             sync1_q, sync1_d;
    logic             stable_q, stable_d;
    logic             stable_dly_q, stable_dly_d;
    logic             press_q, press_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        sync0_d  = nBtn_i;
        sync1_d  = sync0_q;
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync1_q != stable_q) begin
            if (cnt_q == DBNC_TC_W) begin
                stable_d = sync1_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        // Edge detect on the already-registered stable value; release gives no pulse.
        stable_dly_d = stable_q;
        press_d      = stable_dly_q & ~stable_q;
    end

    always_ff @(posedge clk_i or negedge nReset_i) begin
        if (!nReset_i) begin
            sync0_q      <= 1'b1;
            sync1_q      <= 1'b1;
            stable_q     <= 1'b1;
            stable_dly_q <= 1'b1;
            press_q      <= 1'b0;
            cnt_q        <= '0;
        end else begin
            sync0_q      <= sync0_d;
            sync1_q      <= sync1_d;
            stable_q     <= stable_d;
            stable_dly_q <= stable_dly_d;
            press_q      <= press_d;
            cnt_q        <= cnt_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/clock_set_ctrl.sv
// Button-driven time-set controller: captures the live time, lets the user step hours and
// minutes, then issues a one-cycle load strobe to the counter chain. Also drives field blink.
//
// state       | meaning
// ST_RUN      | clock running, waiting for MODE
// ST_SET_HRS  | INC steps shadow hours, MODE moves on
// ST_SET_MINS | INC steps shadow minutes, MODE moves on
// ST_COMMIT   | load strobe low for one cycle, then back to run
module clock_set_ctrl
    import clock_pkg::*;
#(
    parameter int hrs_tc_p   = HRS_TC,
    parameter int mins_tc_p  = MINS_TC,
    parameter int dbnc_tc_p  = DBNC_TC,
    parameter int blink_tc_p = BLINK_TC
) (
    input  logic              clk_i,
    input  logic              nReset_i,
    input  logic              nModeBtn_i,
    input  logic              nIncBtn_i,
    input  logic [TIME_W-1:0] curHrs_i,
    input  logic [TIME_W-1:0] curMins_i,
    output logic [TIME_W-1:0] loadHrs_o,
    output logic [TIME_W-1:0] loadMins_o,
    output logic              nLoadNow_o,
    output logic              setMode_o,
    output logic              hrsBlank_o,
    output logic              minsBlank_o
);

    localparam logic [TIME_W-1:0] HRS_TC_W  = TIME_W'(hrs_tc_p);
    localparam logic [TIME_W-1:0] MINS_TC_W = TIME_W'(mins_tc_p);
    localparam int                BLINK_W   = (blink_tc_p > 0) ? $clog2(blink_tc_p + 1) : 1;
    localparam logic [BLINK_W-1:0] BLINK_TC_W = BLINK_W'(blink_tc_p);

    logic mode_press;
    logic inc_press;

    btn_debounce #(.dbnc_tc_p(dbnc_tc_p)) u_dbnc_mode (
        .clk_i    (clk_i),
        .nReset_i (nReset_i),
        .nBtn_i   (nModeBtn_i),
        .press_o  (mode_press)
    );

    btn_debounce #(.dbnc_tc_p(dbnc_tc_p)) u_dbnc_inc (
        .clk_i    (clk_i),
        .nReset_i (nReset_i),
        .nBtn_i   (nIncBtn_i),
        .press_o  (inc_press)
    );

    set_state_e         state_q, state_d;
    logic [TIME_W-1:0]  hrs_q, hrs_d;
    logic [TIME_W-1:0]  mins_q, mins_d;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               phase_q, phase_d;
    logic               nload_q, nload_d;
    logic               set_mode_q, set_mode_d;
    logic               hrs_blank_q, hrs_blank_d;
    logic               mins_blank_q, mins_blank_d;
    logic               accept_press;

    always_comb begin
        state_d      = state_q;
        hrs_d        = hrs_q;
        mins_d       = mins_q;
        accept_press = 1'b0;

        // MODE is tested first so a simultaneous INC pulse is discarded.
        unique case (state_q)
            ST_RUN: begin
                if (mode_press) begin
                    hrs_d        = clamp_tc(curHrs_i, HRS_TC_W);
                    mins_d       = clamp_tc(curMins_i, MINS_TC_W);
                    state_d      = ST_SET_HRS;
                    accept_press = 1'b1;
                end
            end
            ST_SET_HRS: begin
                if (mode_press) begin
                    state_d      = ST_SET_MINS;
                    accept_press = 1'b1;
                end else if (inc_press) begin
                    hrs_d        = step_wrap(hrs_q, HRS_TC_W);
                    accept_press = 1'b1;
                end
            end
            ST_SET_MINS: begin
                if (mode_press) begin
                    state_d      = ST_COMMIT;
                    accept_press = 1'b1;
                end else if (inc_press) begin
                    mins_d       = step_wrap(mins_q, MINS_TC_W);
                    accept_press = 1'b1;
                end
            end
            ST_COMMIT: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        // Restarting the blink on every edit keeps the edited field visible right away.
        if (accept_press) begin
            blink_cnt_d = '0;
            phase_d     = 1'b0;
        end else if (blink_cnt_q == BLINK_TC_W) begin
            blink_cnt_d = '0;
            phase_d     = ~phase_q;
        end else begin
            blink_cnt_d = blink_cnt_q + 1'b1;
            phase_d     = phase_q;
        end

        nload_d      = (state_d != ST_COMMIT);
        set_mode_d   = (state_d != ST_RUN);
        hrs_blank_d  = (state_d == ST_SET_HRS) & phase_d;
        mins_blank_d = (state_d == ST_SET_MINS) & phase_d;
    end

    always_ff @(posedge clk_i or negedge nReset_i) begin
        if (!nReset_i) begin
            state_q      <= ST_RUN;
            hrs_q        <= '0;
            mins_q       <= '0;
            blink_cnt_q  <= '0;
            phase_q      <= 1'b0;
            nload_q      <= 1'b1;
            set_mode_q   <= 1'b0;
            hrs_blank_q  <= 1'b0;
            mins_blank_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            hrs_q        <= hrs_d;
            mins_q       <= mins_d;
            blink_cnt_q  <= blink_cnt_d;
            phase_q      <= phase_d;
            nload_q      <= nload_d;
            set_mode_q   <= set_mode_d;
            hrs_blank_q  <= hrs_blank_d;
            mins_blank_q <= mins_blank_d;
        end
    end

    assign loadHrs_o   = hrs_q;
    assign loadMins_o  = mins_q;
    assign nLoadNow_o  = nload_q;
    assign setMode_o   = set_mode_q;
    assign hrsBlank_o  = hrs_blank_q;
    assign minsBlank_o = mins_blank_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Scoreboard bench for clock_set_ctrl with short debounce and blink terminal counts.
module tb_clock_set_ctrl;
    import clock_pkg::*;

    localparam int DBNC  = 3;
    localparam int BLINK = 7;

    logic       clk_i = 1'b0;
    logic       nReset_i;
    logic       nModeBtn_i;
    logic       nIncBtn_i;
    logic [6:0] curHrs_i;
    logic [6:0] curMins_i;
    logic [6:0] loadHrs_o;
    logic [6:0] loadMins_o;
    logic       nLoadNow_o;
    logic       setMode_o;
    logic       hrsBlank_o;
    logic       minsBlank_o;

    always #5 clk_i = ~clk_i;

    clock_set_ctrl #(
        .hrs_tc_p   (11),
        .mins_tc_p  (59),
        .dbnc_tc_p  (DBNC),
        .blink_tc_p (BLINK)
    ) dut (
        .clk_i       (clk_i),
        .nReset_i    (nReset_i),
        .nModeBtn_i  (nModeBtn_i),
        .nIncBtn_i   (nIncBtn_i),
        .curHrs_i    (curHrs_i),
        .curMins_i   (curMins_i),
        .loadHrs_o   (loadHrs_o),
        .loadMins_o  (loadMins_o),
        .nLoadNow_o  (nLoadNow_o),
        .setMode_o   (setMode_o),
        .hrsBlank_o  (hrsBlank_o),
        .minsBlank_o (minsBlank_o)
    );

    typedef struct {
        string      tag;
        logic [6:0] hrs;
        logic [6:0] mins;
        logic       nload;
        logic       setm;
        logic       hb;
        logic       mb;
        bit         chk_bl;
    } exp_t;

    exp_t       sb_q[$];
    int         n_chk  = 0;
    int         n_pass = 0;
    set_state_e m_st;
    logic [6:0] m_hrs;
    logic [6:0] m_mins;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        else n_pass++;
    endtask

    function automatic exp_t mk(input string tag, input set_state_e st,
                                input bit chk_bl, input bit blph);
        exp_t e;
        e.tag    = tag;
        e.hrs    = m_hrs;
        e.mins   = m_mins;
        e.nload  = (st != ST_COMMIT);
        e.setm   = (st != ST_RUN);
        e.hb     = (st == ST_SET_HRS) && blph;
        e.mb     = (st == ST_SET_MINS) && blph;
        e.chk_bl = chk_bl;
        return e;
    endfunction

    task automatic pop_check();
        exp_t e;
        if (sb_q.size() == 0) begin
            chk("sb_underflow", 32'd1, 32'd0);
            return;
        end
        e = sb_q.pop_front();
        chk({e.tag, "/hrs"}, loadHrs_o, e.hrs);
        chk({e.tag, "/mins"}, loadMins_o, e.mins);
        chk({e.tag, "/nload"}, nLoadNow_o, e.nload);
        chk({e.tag, "/setm"}, setMode_o, e.setm);
        if (e.chk_bl) begin
            chk({e.tag, "/hblank"}, hrsBlank_o, e.hb);
            chk({e.tag, "/mblank"}, minsBlank_o, e.mb);
        end
    endtask

    // Hold buttons low for 10 edges; the FSM acts on edge 8. Samples edge 7 and edges 8..31.
    task automatic press(input string tag, input bit do_mode, input bit do_inc);
        set_state_e st_new;
        sb_q.push_back(mk({tag, "/pre"}, m_st, 1'b0, 1'b0));
        st_new = m_st;
        case (m_st)
            ST_RUN: if (do_mode) begin
                m_hrs  = (curHrs_i > 7'd11) ? 7'd0 : curHrs_i;
                m_mins = (curMins_i > 7'd59) ? 7'd0 : curMins_i;
                st_new = ST_SET_HRS;
            end
            ST_SET_HRS: begin
                if (do_mode) st_new = ST_SET_MINS;
                else if (do_inc) m_hrs = (m_hrs == 7'd11) ? 7'd0 : m_hrs + 7'd1;
            end
            ST_SET_MINS: begin
                if (do_mode) st_new = ST_COMMIT;
                else if (do_inc) m_mins = (m_mins == 7'd59) ? 7'd0 : m_mins + 7'd1;
            end
            default: ;
        endcase
        for (int k = 0; k < 24; k++) begin
            set_state_e s;
            s = (st_new == ST_COMMIT && k >= 1) ? ST_RUN : st_new;
            sb_q.push_back(mk($sformatf("%s/k%0d", tag, k), s, 1'b1, (k >= 8 && k < 16)));
        end
        m_st = (st_new == ST_COMMIT) ? ST_RUN : st_new;
        nModeBtn_i = !do_mode;
        nIncBtn_i  = !do_inc;
        for (int e = 1; e <= 31; e++) begin
            @(posedge clk_i);
            #1;
            if (e >= 7) pop_check();
            if (e == 10) begin
                nModeBtn_i = 1'b1;
                nIncBtn_i  = 1'b1;
            end
        end
    endtask

    task automatic glitch_mode();
        for (int k = 0; k < 14; k++) sb_q.push_back(mk($sformatf("glitch/c%0d", k), m_st, 1'b1, 1'b0));
        nModeBtn_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1 nModeBtn_i = 1'b1;
        for (int k = 0; k < 14; k++) begin
            @(posedge clk_i);
            #1 pop_check();
        end
    endtask

    task automatic reset_mid();
        m_st   = ST_RUN;
        m_hrs  = 7'd0;
        m_mins = 7'd0;
        sb_q.push_back(mk("rst_async", ST_RUN, 1'b1, 1'b0));
        sb_q.push_back(mk("rst_held", ST_RUN, 1'b1, 1'b0));
        sb_q.push_back(mk("rst_after", ST_RUN, 1'b1, 1'b0));
        @(posedge clk_i);
        #3 nReset_i = 1'b0;
        #1 pop_check();
        @(posedge clk_i);
        #1 pop_check();
        @(negedge clk_i);
        nReset_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1 pop_check();
    endtask

    initial begin
        nReset_i   = 1'b0;
        nModeBtn_i = 1'b1;
        nIncBtn_i  = 1'b1;
        curHrs_i   = 7'd0;
        curMins_i  = 7'd0;
        m_st       = ST_RUN;
        m_hrs      = 7'd0;
        m_mins     = 7'd0;

        repeat (3) @(posedge clk_i);
        #1;
        sb_q.push_back(mk("reset", ST_RUN, 1'b1, 1'b0));
        pop_check();
        @(negedge clk_i);
        nReset_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;

        curHrs_i  = 7'd5;
        curMins_i = 7'd30;
        glitch_mode();
        press("cap_5_30", 1'b1, 1'b0);
        press("to_mins", 1'b1, 1'b0);
        press("commit1", 1'b1, 1'b0);

        curHrs_i  = 7'd10;
        curMins_i = 7'd58;
        press("cap_10_58", 1'b1, 1'b0);
        press("inc_h11", 1'b0, 1'b1);
        press("inc_h0", 1'b0, 1'b1);
        press("inc_h1", 1'b0, 1'b1);
        press("to_mins2", 1'b1, 1'b0);
        press("inc_m59", 1'b0, 1'b1);
        press("inc_m0", 1'b0, 1'b1);
        press("commit2", 1'b1, 1'b0);

        curHrs_i  = 7'd4;
        curMins_i = 7'd75;
        press("cap_bad_mins", 1'b1, 1'b0);
        press("mode_inc_sim", 1'b1, 1'b1);
        press("inc_m1", 1'b0, 1'b1);
        reset_mid();

        press("inc_in_run", 1'b0, 1'b1);
        curHrs_i  = 7'd12;
        curMins_i = 7'd15;
        press("blink_enter", 1'b1, 1'b0);
        press("blink_inc", 1'b0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
